// File: rtl/fpm_pkg.sv
// rtl/fpm_pkg.sv - shared widths, state type and helpers for the FPM mantissa multiplier
package fpm_pkg;

    localparam int PP_W    = 26;
    localparam int NGROUPS = 9;
    localparam int PROD_W  = 48;

    // {pp_neg, pp} is the one's-complement term, sign included
    localparam int TERM_W  = PP_W + 1;
    // Three guard bits above the product so group 8 never wraps mid-sum
    localparam int ACC_W   = PROD_W + 3;
    localparam int GRP_W   = 4;
    localparam int SH_W    = 6;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } booth_acc_state_t;

    // Radix-8 weight 8^g expressed as a left shift of 3*g
    function automatic logic [SH_W-1:0] group_shift(input logic [GRP_W-1:0] g);
        return SH_W'(g) * SH_W'(3);
    endfunction

endpackage

// File: rtl/booth8_pp_accumulator_if.sv
// rtl/booth8_pp_accumulator_if.sv - partial-product in / product out handshake bundle
interface booth8_pp_accumulator_if;
    import fpm_pkg::*;

    logic              clear;
    logic              pp_valid;
    logic              pp_ready;
    logic [PP_W-1:0]   pp;
    logic              pp_neg;
    logic              res_valid;
    logic              res_ready;
    logic [PROD_W-1:0] product;
    logic [GRP_W-1:0]  grp_idx;

    // Booth selector / normaliser side
    modport master (
        output clear, pp_valid, pp, pp_neg, res_ready,
        input  pp_ready, res_valid, product, grp_idx
    );

    // Accumulator side
    modport slave (
        input  clear, pp_valid, pp, pp_neg, res_ready,
        output pp_ready, res_valid, product, grp_idx
    );

endinterface

// File: rtl/booth8_pp_term.sv
// rtl/booth8_pp_term.sv - turns a selector partial product into a signed term plus negation carry
module booth8_pp_term
    import fpm_pkg::*;
(
    input  logic [PP_W-1:0]   pp,
    input  logic              pp_neg,
    output logic [TERM_W-1:0] term,
    output logic              corr
);

    // The selector already inverted pp for negative digits, so prepending the
    // neg bit yields the one's-complement value; the +1 that completes the
    // two's complement is handed back separately so the accumulator can fold
    // it in before weighting. All-ones with neg set becomes -1 + 1 = 0.
    assign term = {pp_neg, pp};
    assign corr = pp_neg;

endmodule

// File: rtl/booth8_pp_accumulator.sv
// rtl/booth8_pp_accumulator.sv - sums radix-8 Booth partial products into the 48-bit mantissa product
module booth8_pp_accumulator
    import fpm_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    booth8_pp_accumulator_if.slave  bus
);

    booth_acc_state_t  state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [GRP_W-1:0]  grp, grp_nxt;
    logic [PROD_W-1:0] prod_q, prod_nxt;

    logic [TERM_W-1:0] term;
    logic              corr;
    logic [ACC_W-1:0]  term_sx;
    logic [ACC_W-1:0]  weighted;
    logic [ACC_W-1:0]  acc_sum;
    logic              last_grp;

    booth8_pp_term u_term (
        .pp     (bus.pp),
        .pp_neg (bus.pp_neg),
        .term   (term),
        .corr   (corr)
    );

    // Sign-extend, complete the negation, then weight by 8^grp
    assign term_sx  = {{(ACC_W-TERM_W){term[TERM_W-1]}}, term} + ACC_W'(corr);
    assign weighted = term_sx << group_shift(grp);
    assign acc_sum  = acc + weighted;
    assign last_grp = (grp == GRP_W'(NGROUPS - 1));

    // Next-state, datapath updates and handshake outputs; clear overrides everything
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        grp_nxt       = grp;
        prod_nxt      = prod_q;
        bus.pp_ready  = 1'b0;
        bus.res_valid = 1'b0;

        case (state)
            ACCUM: begin
                bus.pp_ready = 1'b1;
                if (bus.pp_valid) begin
                    acc_nxt = acc_sum;
                    if (last_grp) begin
                        grp_nxt   = '0;
                        prod_nxt  = acc_sum[PROD_W-1:0];
                        state_nxt = DONE;
                    end else begin
                        grp_nxt = grp + GRP_W'(1);
                    end
                end
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_nxt = ACCUM;
                    acc_nxt   = '0;
                    grp_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ACCUM;
                acc_nxt   = '0;
                grp_nxt   = '0;
            end
        endcase

        // An abort never publishes a partial sum, so product keeps its old value
        if (bus.clear) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            grp_nxt   = '0;
            prod_nxt  = prod_q;
        end
    end

    // State, accumulator, group counter and held product registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ACCUM;
            acc    <= '0;
            grp    <= '0;
            prod_q <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            grp    <= grp_nxt;
            prod_q <= prod_nxt;
        end
    end

    assign bus.product = prod_q;
    assign bus.grp_idx = grp;

endmodule
